// File: rtl/cordic.sv
// Rotation-mode CORDIC, Q16.16, 16 micro-rotations.
// Quadrant pre-rotation, 16 iteration stages, gain correction; 18 registers deep.
module cordic (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] x0,
  input  logic signed [31:0] y0,
  input  logic signed [31:0] z0,
  output logic signed [31:0] x,
  output logic signed [31:0] y
);

  localparam logic signed [31:0] HALF_PI = 32'sd102943;
  localparam logic signed [63:0] INVK    = 64'sd39797;

  function automatic logic signed [31:0] atan(input int i);
    unique case (i)
      0:       atan = 32'sd51472;
      1:       atan = 32'sd30386;
      2:       atan = 32'sd16055;
      3:       atan = 32'sd8150;
      4:       atan = 32'sd4091;
      5:       atan = 32'sd2047;
      6:       atan = 32'sd1024;
      7:       atan = 32'sd512;
      8:       atan = 32'sd256;
      9:       atan = 32'sd128;
      10:      atan = 32'sd64;
      11:      atan = 32'sd32;
      12:      atan = 32'sd16;
      13:      atan = 32'sd8;
      14:      atan = 32'sd4;
      default: atan = 32'sd2;
    endcase
  endfunction

  // xs/ys[0] and zs[0] hold stage P; index i+1 holds stage Ii
  logic signed [31:0] xs [17];
  logic signed [31:0] ys [17];
  logic signed [31:0] zs [16];

  logic signed [31:0] xp, yp, zp;
  logic signed [31:0] xn [16];
  logic signed [31:0] yn [16];
  logic signed [31:0] zn [15];

  always_comb begin
    xp = x0;
    yp = y0;
    zp = z0;
    if (z0 > HALF_PI) begin
      xp = -y0;
      yp = x0;
      zp = z0 - HALF_PI;
    end else if (z0 < -HALF_PI) begin
      xp = y0;
      yp = -x0;
      zp = z0 + HALF_PI;
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      if (!zs[i][31]) begin
        xn[i] = xs[i] - (ys[i] >>> i);
        yn[i] = ys[i] + (xs[i] >>> i);
      end else begin
        xn[i] = xs[i] + (ys[i] >>> i);
        yn[i] = ys[i] - (xs[i] >>> i);
      end
    end
  end

  // the last stage's residual angle is never consumed
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      if (!zs[i][31]) zn[i] = zs[i] - atan(i);
      else            zn[i] = zs[i] + atan(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 17; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
      end
      for (int i = 0; i < 16; i++) zs[i] <= '0;
      x <= '0;
      y <= '0;
    end else begin
      xs[0] <= xp;
      ys[0] <= yp;
      zs[0] <= zp;
      for (int i = 0; i < 16; i++) begin
        xs[i+1] <= xn[i];
        ys[i+1] <= yn[i];
      end
      for (int i = 0; i < 15; i++) zs[i+1] <= zn[i];
      x <= 32'((64'(xs[16]) * INVK) >>> 16);
      y <= 32'((64'(ys[16]) * INVK) >>> 16);
    end
  end

endmodule

// File: tb/tb_cordic.sv
// Bench for cordic: ideal trig model with 18-deep latency queue,
// directed literal points, random stream and mid-stream reset.
module tb_cordic;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] x0 = '0;
  logic signed [31:0] y0 = '0;
  logic signed [31:0] z0 = '0;
  logic signed [31:0] x, y;

  int  checks = 0;
  int  passed = 0;
  real mx [18];
  real my [18];
  bit  mz [18];

  cordic dut (
    .clk(clk),
    .rst(rst),
    .x0(x0),
    .y0(y0),
    .z0(z0),
    .x(x),
    .y(y)
  );

  always #5 clk = ~clk;

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic real ideal(input bit isy, input int a, input int b,
                                input int c);
    real t;
    t = $itor(c) / 65536.0;
    if (isy) return $itor(b) * $cos(t) + $itor(a) * $sin(t);
    return $itor(a) * $cos(t) - $itor(b) * $sin(t);
  endfunction

  task automatic clear_model;
    for (int i = 0; i < 18; i++) begin
      mz[i] = 1'b1;
      mx[i] = 0.0;
      my[i] = 0.0;
    end
  endtask

  // advance one clock, record what was sampled, check the 18-deep output
  task automatic tick;
    bit ok;
    @(posedge clk);
    #1;
    for (int i = 17; i > 0; i--) begin
      mz[i] = mz[i-1];
      mx[i] = mx[i-1];
      my[i] = my[i-1];
    end
    if (rst) begin
      mz[0] = 1'b1;
      mx[0] = 0.0;
      my[0] = 0.0;
    end else begin
      mz[0] = 1'b0;
      mx[0] = ideal(1'b0, x0, y0, z0);
      my[0] = ideal(1'b1, x0, y0, z0);
    end
    checks++;
    if (mz[17]) ok = (x === 32'sd0) && (y === 32'sd0);
    else ok = (rabs($itor(x) - mx[17]) <= 32.0) &&
              (rabs($itor(y) - my[17]) <= 32.0);
    if (ok) passed++;
    else $display("FAIL stream t=%0t x=%0d y=%0d required x=%0f y=%0f",
                  $time, x, y, mx[17], my[17]);
  endtask

  task automatic zchk(input string n);
    checks++;
    if ((x === 32'sd0) && (y === 32'sd0)) passed++;
    else $display("FAIL %s x=%0d y=%0d required x=0 y=0", n, x, y);
  endtask

  task automatic lit(input string n, input int ex, input int ey);
    checks++;
    if ((rabs($itor(x) - $itor(ex)) <= 32.0) &&
        (rabs($itor(y) - $itor(ey)) <= 32.0)) passed++;
    else $display("FAIL %s x=%0d y=%0d required x=%0d y=%0d +/-32",
                  n, x, y, ex, ey);
  endtask

  task automatic dir(input string n, input int a, input int b, input int c,
                     input int ex, input int ey);
    x0 = a;
    y0 = b;
    z0 = c;
    tick;
    x0 = '0;
    y0 = '0;
    z0 = '0;
    repeat (17) tick;
    lit(n, ex, ey);
  endtask

  initial begin
    clear_model;
    #2;
    zchk("reset_state");
    repeat (3) tick;
    rst = 1'b0;

    dir("rot_0",      65536,     0,       0,  65536,      0);
    dir("rot_pi4",    65536,     0,   51472,  46341,  46341);
    dir("rot_pi2",    65536,     0,  102943,      0,  65536);
    dir("rot_pi",     65536,     0,  205887, -65536,      0);
    dir("rot_m_pi2",  65536,     0, -102943,      0, -65536);
    dir("y_rot_pi2",      0, 65536,  102943, -65536,      0);
    dir("rot_m_pi",   65536,     0, -205887, -65536,      0);

    x0 = 65536;
    y0 = '0;
    z0 = 0;
    tick;
    z0 = 51472;
    tick;
    z0 = 102943;
    tick;
    x0 = '0;
    z0 = '0;
    repeat (15) tick;
    lit("b2b_0", 65536, 0);
    tick;
    lit("b2b_1", 46341, 46341);
    tick;
    lit("b2b_2", 0, 65536);

    for (int k = 0; k < 300; k++) begin
      x0 = int'($urandom_range(0, 131072)) - 65536;
      y0 = int'($urandom_range(0, 131072)) - 65536;
      z0 = int'($urandom_range(0, 411774)) - 205887;
      if (k == 150) begin
        #2 rst = 1'b1;
        #1 zchk("async_reset");
        clear_model;
        tick;
        tick;
        rst = 1'b0;
      end
      tick;
    end

    x0 = '0;
    y0 = '0;
    z0 = '0;
    repeat (18) tick;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cordic.md
CORDIC -- requirements
Module: cordic

Interface
REQ-001 Parameters: none; word width fixed at 32, format signed two's-complement Q16.16 (1.0 = 65536), 16 iterations.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 x0  input  32  signed Q16.16 input vector X component.
REQ-005 y0  input  32  signed Q16.16 input vector Y component.
REQ-006 z0  input  32  signed Q16.16 rotation angle in radians, range [-pi, +pi] (pi = 205887).
REQ-007 x  output  32  signed Q16.16 rotated X = x0*cos(z0) - y0*sin(z0), gain-compensated, registered.
REQ-008 y  output  32  signed Q16.16 rotated Y = y0*cos(z0) + x0*sin(z0), gain-compensated, registered.

Function
REQ-009 Rotation-mode CORDIC, fully pipelined: stage P (quadrant pre-rotation), stages I0..I15 (one micro-rotation each), stage G (gain correction); every stage is one register set.
REQ-010 Stage P, with HALF_PI = 102943: if z0 > HALF_PI then (x,y,z) <= (-y0, x0, z0-HALF_PI); else if z0 < -HALF_PI then (x,y,z) <= (y0, -x0, z0+HALF_PI); else pass through unchanged.
REQ-011 Stage Ii (i = 0..15): d = +1 if z >= 0 else -1; x' = x - d*(y >>> i); y' = y + d*(x >>> i); z' = z - d*ATAN[i]; >>> is arithmetic shift.
REQ-012 ATAN table (Q16.16, i = 0..15): 51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2.
REQ-013 Stage G: x = (x15' * 39797) >>> 16 and y = (y15' * 39797) >>> 16, computed with a 64-bit signed product, truncated to 32 bits (39797 = 1/K in Q16.16).
REQ-014 All adds/subtracts are 32-bit two's complement and wrap on overflow; no saturation.
REQ-015 Overflow-free operation is guaranteed for |x0|, |y0| <= 2^29; larger magnitudes produce wrapped (undefined-value) results.
REQ-016 Latency: inputs sampled on posedge N appear on x, y immediately after posedge N+17 (18 register stages).
REQ-017 Throughput: one new input set accepted every clock; no handshake or stall; inputs are sampled unconditionally every cycle.
REQ-018 Accuracy: for in-range inputs, |x - ideal|, |y - ideal| <= 32 LSB.
REQ-019 z0 outside [-pi, +pi] is unsupported; the output is whatever the datapath produces, with no error flag.
REQ-020 The residual angle is internal only and is not an output.

Reset
REQ-021 While rst = 1, every pipeline register (x, y, z of all stages, including outputs) is asynchronously forced to 0.
REQ-022 After rst deasserts, x = y = 0 until the first post-reset sample reaches stage G (18 posedges); in-flight data at reset assertion is discarded.

Verification
REQ-023 x0=65536, y0=0, z0=102943 (pi/2) -> after 18 clocks y = 65536 +/-32, x = 0 +/-32.
REQ-024 x0=65536, y0=0, z0=0 -> x = 65536 +/-32, y = 0 +/-32; z0=51472 (pi/4) -> x = y = 46341 +/-32.
REQ-025 x0=65536, y0=0, z0=205887 (pi) -> x = -65536 +/-32, y = 0 +/-32; z0=-102943 -> y = -65536 +/-32, x = 0 +/-32.
REQ-026 Back-to-back inputs with z0 = 0, 51472, 102943 on consecutive clocks -> matching results on three consecutive output cycles starting at latency 18.
REQ-027 rst pulse asserted mid-stream -> x = y = 0 immediately (asynchronously), remaining 0 for 18 clocks after release, then new results.
REQ-028 x0=0, y0=65536, z0=102943 -> x = -65536 +/-32, y = 0 +/-32.
